pla7_truth_table_scanner: RTL and testbench

Sequential stimulus/response companion for the combinational N_IN-input, single-output PLA benchmark netlists. It sweeps every input vector from 0 to 2^N_IN-1 onto the netlist inputs and samples the netlist output after a programmable settle window. It assembles the complete truth table and its on-set size, and is used to cross-check optimized netlists against their original PLA.

---
 rtl/pla7_truth_table_scanner.sv | 126 ++++++++++++
 tb/tb_pla7_truth_table_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pla7_truth_table_scanner.sv
// Truth-table scanner for single-output PLA netlists.
// Sweeps all input vectors, samples y after a settle window.
module pla7_truth_table_scanner #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      x_out,
  input  logic                 y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        ones_count
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] XMAX = '1;
  localparam logic [3:0] CMAX = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FIN
  } state_e;

  state_e state_q, state_d;

  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            go;
  logic            samp;
  logic            last;

  assign go   = start && !abort;
  assign samp = (state_q == HOLD) && !abort
                && (cnt_q == CMAX);
  assign last = (x_q == XMAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = HOLD;
      HOLD: begin
        if (abort)             state_d = IDLE;
        else if (samp && last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    x_d    = x_q;
    cnt_d  = cnt_q;
    tt_d   = tt_q;
    ones_d = ones_q;
    busy_d = (state_d == HOLD);
    done_d = (state_d == FIN);
    unique case (state_q)
      IDLE: begin
        if (go) begin
          x_d    = '0;
          cnt_d  = '0;
          tt_d   = '0;
          ones_d = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          x_d   = '0;
          cnt_d = '0;
        end else if (samp) begin
          tt_d[x_q] = y_in;
          ones_d    = ones_q + {{N_IN{1'b0}}, y_in};
          cnt_d     = '0;
          x_d       = last ? '0 : x_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FIN:     x_d = '0;
      default: x_d = '0;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      cnt_q  <= '0;
      tt_q   <= '0;
      ones_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      tt_q   <= tt_d;
      ones_q <= ones_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tt         = tt_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_pla7_truth_table_scanner.sv
// Randomized self-checking bench for the scanner.
// Reference: truth table computed directly from f(i).
module tb_pla7_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;
  logic [127:0] rnd_tt = '0;

  logic [6:0]   xa, xb, x_m;
  logic         ya, yb;
  logic         busy_a, busy_b, busy_m;
  logic         done_a, done_b, done_m;
  logic [127:0] tt_a, tt_b, tt_m;
  logic [7:0]   oc_a, oc_b, oc_m;
  logic         p1, p2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pla7_truth_table_scanner #(.N_IN(7), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .start(start & ~sel), .abort(abort & ~sel),
    .x_out(xa), .y_in(ya),
    .busy(busy_a), .done(done_a),
    .tt(tt_a), .ones_count(oc_a)
  );

  pla7_truth_table_scanner #(.N_IN(7), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .start(start & sel), .abort(abort & sel),
    .x_out(xb), .y_in(yb),
    .busy(busy_b), .done(done_b),
    .tt(tt_b), .ones_count(oc_b)
  );

  function automatic bit fref(int m, int i);
    case (m)
      0:       return i[0];
      1:       return i == 127;
      2:       return 1'b1;
      3:       return rnd_tt[i];
      default: return i[6];
    endcase
  endfunction

  function automatic logic [127:0] exp_tt(int m, int upto);
    logic [127:0] t = '0;
    for (int i = 0; i < upto; i++) t[i] = fref(m, i);
    return t;
  endfunction

  always_comb ya = fref(mode, int'(xa));

  always_ff @(posedge clk) begin
    p1 <= xb[6];
    p2 <= p1;
  end
  assign yb = p2;

  assign x_m    = sel ? xb : xa;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign tt_m   = sel ? tt_b : tt_a;
  assign oc_m   = sel ? oc_b : oc_a;

  task automatic chk(string tag,
                     logic [127:0] got,
                     logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(int m, int s, int restart);
    logic [127:0] e;
    int n;
    mode = m;
    sel  = (s == 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy_m, 1);
    chk("start_x", x_m, 0);
    chk("start_ones", oc_m, 0);
    chk("start_tt", tt_m, 0);
    n = 0;
    while (!done_m && n < 2000) begin
      if (n == restart - 1) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    e = exp_tt(m, 128);
    chk("latency", n, 128 * s);
    chk("tt", tt_m, e);
    chk("ones", oc_m, $countones(e));
    chk("fin_busy", busy_m, 0);
    chk("fin_x", x_m, 0);
    tick();
    chk("done_pulse", done_m, 0);
    chk("idle_busy", busy_m, 0);
  endtask

  task automatic abort_scan(int m, int k);
    logic [127:0] e;
    logic seen;
    mode = m;
    sel  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (k) tick();
    chk("abort_xk", x_m, k);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    e = exp_tt(m, k);
    chk("abort_busy", busy_m, 0);
    chk("abort_x", x_m, 0);
    chk("abort_tt", tt_m, e);
    chk("abort_ones", oc_m, $countones(e));
    seen = done_m;
    repeat (4) begin
      tick();
      seen |= done_m | busy_m;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_hold", tt_m, e);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_x", xa, 0);
    chk("rst_tt", tt_a, 0);
    chk("rst_ones", oc_a, 0);
    rst_n = 1'b1;
    tick();

    scan(0, 1, -1);
    scan(1, 1, -1);
    scan(2, 1, -1);
    scan(4, 3, -1);
    scan(2, 1, 50);
    abort_scan(2, 10);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy_a, 0);
    tick();
    chk("sa_busy2", busy_a, 0);
    chk("sa_tt_hold", tt_a, exp_tt(2, 10));

    for (int r = 0; r < 4; r++) begin
      rnd_tt = {$urandom, $urandom, $urandom, $urandom};
      scan(3, 1, -1);
      abort_scan(3, int'($urandom_range(0, 127)));
    end

    mode = 2;
    sel  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_x", xa, 0);
    chk("arst_tt", tt_a, 0);
    chk("arst_ones", oc_a, 0);
    chk("arst_done", done_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    scan(0, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
